dispcontrol: RTL and testbench

- Drives an 8x8 LED matrix from an internal 8-row frame buffer.
- Upstream logic (Game-of-Life cell array or a pattern generator) writes one 8-bit row per clock, selected by a 3-bit row address.
- The block time-multiplexes the rows onto the matrix: one row anode is active at a time and the column cathodes carry that row's pixels.
- It sits between the cell-state logic and the board pins.

---
 rtl/disp_pkg.sv | 11 +
 rtl/scan_timer.sv | 44 ++++
 rtl/dispcontrol.sv | 71 +++++++
 tb/tb_dispcontrol.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 8x8 LED matrix display controller.
// No ports: this package is imported by scan_timer and dispcontrol.
package disp_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 8;

    typedef logic [2:0]          row_idx_t;
    typedef logic [NUM_COLS-1:0] row_bits_t;

endpackage

// File: rtl/scan_timer.sv
// Row scan timing for the LED matrix.
// The dwell counter runs 0..DWELL_CYCLES-1.
// The scan index advances by one (modulo 8) each time the counter wraps.
// The first BLANK_CYCLES counts of every dwell are flagged as blanked.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   scan_idx row currently being scanned
//   blank    high while the dwell counter is inside the blanking window
module scan_timer
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    output row_idx_t scan_idx,
    output logic     blank
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;

    logic [CW-1:0] dwell_cnt;
    row_idx_t      idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
            idx       <= '0;
        end else if (dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
            dwell_cnt <= '0;
            // A 3-bit index wraps from 7 to 0 on its own.
            idx       <= idx + 3'd1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    assign scan_idx = idx;
    assign blank    = (dwell_cnt < CW'(BLANK_CYCLES));

endmodule

// File: rtl/dispcontrol.sv
// 8x8 LED matrix driver with an internal 8-row frame buffer.
// Upstream logic writes one row on every clock edge: frame[addr] <= bit_in.
// There is no valid/ready handshake and no write enable.
// To leave the frame unchanged, upstream rewrites a row with its current value.
// Rows are time-multiplexed onto the matrix.
// row is a one-hot, active-high anode select.
// col is the active-low cathode drive for the selected row.
// Both outputs are registered.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   addr   frame-buffer row written this cycle
//   bit_in pixel data for row addr (bit k = column k, 1 = LED on)
//   row    one-hot row select, all-zero while blanked
//   col    active-low column drive, ~pixels of the selected row
module dispcontrol
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  row_idx_t  addr,
    input  row_bits_t bit_in,
    output row_bits_t row,
    output row_bits_t col
);

    row_bits_t frame [NUM_ROWS];
    row_idx_t  scan_idx;
    logic      blank;

    scan_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan_timer (
        .clk      (clk),
        .reset    (reset),
        .scan_idx (scan_idx),
        .blank    (blank)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                frame[i] <= '0;
            end
        end else begin
            frame[addr] <= bit_in;
        end
    end

    // The outputs read the pre-edge frame contents.
    // A write therefore reaches col one cycle after it lands in the buffer.
    // As a result, a row is never torn within a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '1;
        end else if (blank) begin
            row <= '0;
            col <= '1;
        end else begin
            row <= row_bits_t'(1) << scan_idx;
            col <= ~frame[scan_idx];
        end
    end

endmodule

// File: tb/tb_dispcontrol.sv
module tb_dispcontrol;

    localparam int D = 4;
    localparam int B = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] addr;
    logic [7:0] bit_in;
    logic [7:0] row;
    logic [7:0] col;

    always #5 clk = ~clk;

    dispcontrol #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .bit_in (bit_in),
        .row    (row),
        .col    (col)
    );

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  frame_m [8];
    int          e_cnt;        // edges since reset release
    logic [15:0] exp_q [$];    // expected {row, col}
    logic [15:0] last_exp;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // Output after edge e: timing follows from plain arithmetic on e.
    // The pixels come from the frame as it stood before that edge.
    function automatic logic [15:0] model_out(input int e);
        int r;
        if ((e % D) < B) return {8'h00, 8'hFF};
        r = (e / D) % 8;
        return {8'h01 << r, ~frame_m[r]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e_cnt);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) frame_m[i] = 8'h00;
        e_cnt = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [2:0] a, input logic [7:0] d);
        logic [15:0] got;
        addr   = a;
        bit_in = d;
        @(posedge clk);
        exp_q.push_back(model_out(e_cnt));
        frame_m[a] = d;
        e_cnt++;
        @(negedge clk);
        got      = {row, col};
        last_exp = exp_q.pop_front();
        chk("scan", got, last_exp);
        chk("onehot0", {15'd0, $onehot0(row)}, 16'd1);
        if (row == 8'h00) chk("blank_col", {8'h00, col}, 16'h00FF);
    endtask

    // Rewrites a random row with its current contents, leaving the frame unchanged.
    task automatic hold();
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        step(a, frame_m[a]);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("reset_async", {row, col}, 16'h00FF);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] pat [8];
    int         n;

    initial begin
        pat[0] = 8'hE0; pat[1] = 8'h8A; pat[2] = 8'hEA; pat[3] = 8'h8E;
        pat[4] = 8'h00; pat[5] = 8'hEB; pat[6] = 8'h8C; pat[7] = 8'hEB;
        reset  = 1'b1;
        addr   = '0;
        bit_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_init", {row, col}, 16'h00FF);
        reset = 1'b0;

        // Empty buffer scan.
        repeat (12) step(3'($urandom_range(0, 7)), 8'h00);

        // Pattern load, then two full frames.
        for (int i = 0; i < 8; i++) step(3'(i), pat[i]);
        repeat (2 * 8 * D) hold();

        // Live update while row 2 is displayed, with room for one more unblanked cycle.
        n = 0;
        while (!(((e_cnt / D) % 8 == 2) && ((e_cnt % D) >= B) && ((e_cnt % D) <= D - 2)) && n < 64) begin
            hold();
            n++;
        end
        chk("live_found", {15'd0, n < 64}, 16'd1);
        step(3'd2, 8'h81);
        hold();
        chk("live_update", {row, col}, 16'h047E);

        // Off-row write while row 0 is active.
        n = 0;
        while (!(((e_cnt / D) % 8 == 0) && ((e_cnt % D) >= B)) && n < 64) begin
            hold();
            n++;
        end
        chk("off_found", {15'd0, n < 64}, 16'd1);
        step(3'd6, 8'hFF);
        n = 0;
        do begin
            hold();
            n++;
        end while (row != 8'h40 && n < 64);
        chk("off_row", {row, col}, 16'h4000);

        // Random writes mixed with holds.
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) hold();
            else step(3'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset while a row is lit.
        n = 0;
        while (last_exp[15:8] == 8'h00 && n < 16) begin
            hold();
            n++;
        end
        do_reset();
        repeat (3 * 8 * D) step(3'($urandom_range(0, 7)), 8'h00);
        repeat (100) step(3'($urandom_range(0, 7)), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
